// File: rtl/sd_access_sched.sv
// sd_access_sched: arbitrates the shared SD SPI bus between the init, block-write
// and block-read engines. Nothing is granted until init completes. After that, one
// sector request is served at a time, with round-robin between the write and read
// requesters. Each granted operation ends in done, or in err on timeout.
// Optional build macro: SD_SCHED_STATS_EN adds saturating wr_cnt/rd_cnt/err_cnt
// outputs that count completed writes, completed reads and timeouts.
module sd_access_sched #(
  parameter int              TO_W        = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = TO_W'(2500000)
) (
  input  logic        SD_clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [31:0] wr_sec,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [31:0] rd_sec,
  output logic        rd_ack,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [3:0]  state,
  input  logic        init_done,
  output logic [31:0] eng_sec,
  output logic        eng_wr_req,
  output logic        eng_rd_req,
  input  logic        eng_wr_done,
  input  logic        eng_rd_done,
  input  logic        SD_cs_i,
  input  logic        SD_datain_i,
  input  logic        SD_cs_w,
  input  logic        SD_datain_w,
  input  logic        SD_cs_r,
  input  logic        SD_datain_r,
  output logic        SD_cs,
  output logic        SD_datain
`ifdef SD_SCHED_STATS_EN
  ,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_IDLE  = 4'd1,
    S_ISSUE = 4'd2,
    S_WAIT  = 4'd3,
    S_DONE  = 4'd4,
    S_ERR   = 4'd5
  } state_t;

  state_t          st, st_n;
  logic            op_wr, op_wr_n;         // 1: granted op is a write
  logic            last_rd, last_rd_n;     // 1: read was served last
  logic [TO_W-1:0] cnt, cnt_n;
  logic            done_prev, done_prev_n;
  logic            wr_ack_n, rd_ack_n, done_n, err_n, busy_n;
  logic            eng_wr_req_n, eng_rd_req_n;
  logic [31:0]     eng_sec_n;
  logic            done_in;
  logic            timeout_hit;

  assign state       = st;
  assign done_in     = op_wr ? eng_wr_done : eng_rd_done;
  assign timeout_hit = (cnt == (TIMEOUT_CYC - TO_W'(1)));

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    st_n         = st;
    op_wr_n      = op_wr;
    last_rd_n    = last_rd;
    cnt_n        = cnt;
    done_prev_n  = done_prev;
    eng_sec_n    = eng_sec;
    wr_ack_n     = 1'b0;
    rd_ack_n     = 1'b0;
    done_n       = 1'b0;
    err_n        = 1'b0;
    eng_wr_req_n = 1'b0;
    eng_rd_req_n = 1'b0;
    case (st)
      S_INIT: begin
        if (init_done) st_n = S_IDLE;
      end
      S_IDLE: begin
        if (!init_done) begin
          st_n = S_INIT;
        end else if (wr_req && (!rd_req || last_rd)) begin
          // A write wins a tie only when the read was served last.
          wr_ack_n  = 1'b1;
          eng_sec_n = wr_sec;
          op_wr_n   = 1'b1;
          last_rd_n = 1'b0;
          st_n      = S_ISSUE;
        end else if (rd_req) begin
          rd_ack_n  = 1'b1;
          eng_sec_n = rd_sec;
          op_wr_n   = 1'b0;
          last_rd_n = 1'b1;
          st_n      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_wr_req_n = op_wr;
        eng_rd_req_n = !op_wr;
        cnt_n        = '0;
        // Capture the done level now, so a done input already high does not look like completion.
        done_prev_n  = done_in;
        st_n         = S_WAIT;
      end
      S_WAIT: begin
        done_prev_n = done_in;
        if (done_in && !done_prev) begin
          done_n = 1'b1;
          st_n   = S_DONE;
        end else if (timeout_hit) begin
          err_n = 1'b1;
          st_n  = S_ERR;
        end else begin
          cnt_n = cnt + TO_W'(1);
        end
      end
      S_DONE:  st_n = S_IDLE;
      S_ERR:   st_n = S_INIT;
      default: st_n = S_INIT;
    endcase
    busy_n = (st_n != S_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge SD_clk) begin
    if (rst) begin
      st         <= S_INIT;
      op_wr      <= 1'b0;
      last_rd    <= 1'b1;
      cnt        <= '0;
      done_prev  <= 1'b0;
      eng_sec    <= '0;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b1;
      eng_wr_req <= 1'b0;
      eng_rd_req <= 1'b0;
    end else begin
      st         <= st_n;
      op_wr      <= op_wr_n;
      last_rd    <= last_rd_n;
      cnt        <= cnt_n;
      done_prev  <= done_prev_n;
      eng_sec    <= eng_sec_n;
      wr_ack     <= wr_ack_n;
      rd_ack     <= rd_ack_n;
      done       <= done_n;
      err        <= err_n;
      busy       <= busy_n;
      eng_wr_req <= eng_wr_req_n;
      eng_rd_req <= eng_rd_req_n;
    end
  end

  // Bus mux: init engine in INIT, granted engine in ISSUE/WAIT, otherwise idle-high.
  always_comb begin
    SD_cs     = 1'b1;
    SD_datain = 1'b1;
    case (st)
      S_INIT: begin
        SD_cs     = SD_cs_i;
        SD_datain = SD_datain_i;
      end
      S_ISSUE, S_WAIT: begin
        SD_cs     = op_wr ? SD_cs_w     : SD_cs_r;
        SD_datain = op_wr ? SD_datain_w : SD_datain_r;
      end
      default: begin
        SD_cs     = 1'b1;
        SD_datain = 1'b1;
      end
    endcase
  end

`ifdef SD_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Completion and timeout counters, saturating, cleared by reset.
  always_ff @(posedge SD_clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (st == S_DONE && op_wr)  wr_cnt  <= sat_inc(wr_cnt);
      if (st == S_DONE && !op_wr) rd_cnt  <= sat_inc(rd_cnt);
      if (st == S_ERR)            err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule
